neuron_sweep_ctrl: RTL and testbench

Sequencer for a single neuron core. On each global tick it walks every neuron index in order. For each neuron it reads that neuron's state and parameters from core memory, lets the combinational neuron integrate/threshold datapath evaluate, writes the updated potential back, and emits a spike event when the neuron fires. It sits between the tick distribution network, the core's neuron/synapse memories, the neuron datapath, and the spike router.

---
 rtl/neuron_sweep_ctrl.sv | 124 ++++++++++++
 tb/tb_neuron_sweep_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/neuron_sweep_ctrl.sv
// Per-tick sweep sequencer for one neuron core: reads each neuron, lets the
// datapath evaluate, writes the new potential back and forwards spikes.
module neuron_sweep_ctrl #(
    parameter int NUM_NEURONS     = 256,
    parameter int POTENTIAL_WIDTH = 9,
    parameter int ADDR_WIDTH      = $clog2(NUM_NEURONS)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       tick_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       tick_overrun_o,
    output logic                       mem_rd_en_o,
    output logic [ADDR_WIDTH-1:0]      mem_addr_o,
    output logic                       mem_wr_en_o,
    output logic [POTENTIAL_WIDTH-1:0] mem_wr_data_o,
    input  logic [POTENTIAL_WIDTH-1:0] nb_write_potential_i,
    input  logic                       nb_spike_i,
    output logic                       spike_valid_o,
    output logic [ADDR_WIDTH-1:0]      spike_id_o,
    input  logic                       spike_ready_i
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        COMPUTE,
        WRITE,
        SPIKE_WAIT,
        DONE
    } state_t;

    state_t                     state;
    logic [ADDR_WIDTH-1:0]      n;
    logic [POTENTIAL_WIDTH-1:0] pot_q;
    logic                       spk_q;
    logic                       rd_en_q;
    logic                       wr_en_q;
    logic                       valid_q;
    logic                       done_q;
    logic                       overrun_q;
    logic                       last;
    logic                       advance;

    always_comb begin
        last    = (n == ADDR_WIDTH'(NUM_NEURONS - 1));
        advance = ((state == WRITE) && (!spk_q || spike_ready_i)) ||
                  ((state == SPIKE_WAIT) && spike_ready_i);
    end

    // Strobes are registered alongside the state they belong to, so each one
    // is set on the transition into its state and cleared on the way out.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            n         <= '0;
            pot_q     <= '0;
            spk_q     <= 1'b0;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (tick_i && (state != IDLE))
                overrun_q <= 1'b1;
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick_i) begin
                        n       <= '0;
                        state   <= READ;
                        rd_en_q <= 1'b1;
                    end
                end
                READ: begin
                    state <= COMPUTE;
                end
                COMPUTE: begin
                    pot_q   <= nb_write_potential_i;
                    spk_q   <= nb_spike_i;
                    valid_q <= nb_spike_i;
                    wr_en_q <= 1'b1;
                    state   <= WRITE;
                end
                WRITE, SPIKE_WAIT: begin
                    if (advance) begin
                        valid_q <= 1'b0;
                        if (last) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            n       <= n + 1'b1;
                            state   <= READ;
                            rd_en_q <= 1'b1;
                        end
                    end else begin
                        state <= SPIKE_WAIT;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy_o         = (state != IDLE);
    assign done_o         = done_q;
    assign tick_overrun_o = overrun_q;
    assign mem_rd_en_o    = rd_en_q;
    assign mem_wr_en_o    = wr_en_q;
    assign mem_addr_o     = n;
    assign mem_wr_data_o  = pot_q;
    assign spike_valid_o  = valid_q;
    assign spike_id_o     = n;

endmodule

// File: tb/tb_neuron_sweep_ctrl.sv
// Bench for neuron_sweep_ctrl: random sweeps compared cycle by cycle against
// a schedule computed from the sweep timing rules.
module tb_neuron_sweep_ctrl;

    localparam int NN   = 4;
    localparam int PW   = 9;
    localparam int AW   = 2;
    localparam int MAXC = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          tick;
    logic          ready;
    logic          busy;
    logic          done;
    logic          overrun;
    logic          rd_en;
    logic [AW-1:0] addr;
    logic          wr_en;
    logic [PW-1:0] wr_data;
    logic [PW-1:0] nb_pot;
    logic          nb_spk;
    logic          valid;
    logic [AW-1:0] spike_id;

    neuron_sweep_ctrl #(
        .NUM_NEURONS    (NN),
        .POTENTIAL_WIDTH(PW),
        .ADDR_WIDTH     (AW)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .tick_i              (tick),
        .busy_o              (busy),
        .done_o              (done),
        .tick_overrun_o      (overrun),
        .mem_rd_en_o         (rd_en),
        .mem_addr_o          (addr),
        .mem_wr_en_o         (wr_en),
        .mem_wr_data_o       (wr_data),
        .nb_write_potential_i(nb_pot),
        .nb_spike_i          (nb_spk),
        .spike_valid_o       (valid),
        .spike_id_o          (spike_id),
        .spike_ready_i       (ready)
    );

    always #5 clk = ~clk;

    // Neuron memory plus datapath: synchronous read, result visible in COMPUTE.
    logic [PW-1:0] pot_tab [NN];
    logic          spk_tab [NN];
    logic [AW-1:0] rd_addr = '0;
    always @(posedge clk) if (rd_en) rd_addr <= addr;
    assign nb_pot = pot_tab[rd_addr];
    assign nb_spk = spk_tab[rd_addr];

    int passed = 0;
    int total  = 0;
    bit ovr_model = 1'b0;

    bit            e_busy [MAXC];
    bit            e_rd   [MAXC];
    bit            e_wr   [MAXC];
    bit            e_val  [MAXC];
    bit            e_done [MAXC];
    int            e_addr [MAXC];
    int            e_id   [MAXC];
    logic [PW-1:0] e_data [MAXC];
    bit            rdy    [MAXC];
    bit            tk     [MAXC];
    int            stall  [NN];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},    32'(busy),     0);
        chk({tag, "_done"},    32'(done),     0);
        chk({tag, "_overrun"}, 32'(overrun),  0);
        chk({tag, "_rd_en"},   32'(rd_en),    0);
        chk({tag, "_wr_en"},   32'(wr_en),    0);
        chk({tag, "_addr"},    32'(addr),     0);
        chk({tag, "_wr_data"}, 32'(wr_data),  0);
        chk({tag, "_valid"},   32'(valid),    0);
        chk({tag, "_id"},      32'(spike_id), 0);
    endtask

    // mode 0: random neurons; 1: only neuron 1 fires with a 5-cycle stall,
    // neuron 0 writes -256, extra ticks at cycle 5 and in the DONE cycle;
    // 2: random neurons plus random stray ticks. rst_at >= 0 resets mid-sweep.
    task automatic run_sweep(input int mode, input int rst_at);
        int t;
        int last;
        int stop;
        for (int c = 0; c < MAXC; c++) begin
            e_busy[c] = 0; e_rd[c] = 0; e_wr[c] = 0; e_val[c] = 0; e_done[c] = 0;
            e_addr[c] = 0; e_id[c] = 0; e_data[c] = '0; tk[c] = 0;
            rdy[c] = bit'($urandom_range(0, 1));
        end
        for (int k = 0; k < NN; k++) begin
            pot_tab[k] = PW'($urandom_range(0, 511));
            spk_tab[k] = 1'($urandom_range(0, 1));
            stall[k]   = $urandom_range(0, 4);
        end
        if (mode == 1) begin
            for (int k = 0; k < NN; k++) spk_tab[k] = 1'b0;
            spk_tab[1] = 1'b1;
            stall[1]   = 5;
            pot_tab[0] = 9'h100;
        end
        tk[0] = 1;
        t = 1;
        for (int k = 0; k < NN; k++) begin
            e_rd[t] = 1;       e_addr[t] = k;
            e_wr[t + 2] = 1;   e_addr[t + 2] = k;
            e_data[t + 2] = pot_tab[k];
            if (spk_tab[k]) begin
                for (int j = 0; j <= stall[k]; j++) begin
                    e_val[t + 2 + j] = 1;
                    e_id[t + 2 + j]  = k;
                    rdy[t + 2 + j]   = (j == stall[k]);
                end
                t += 3 + stall[k];
            end else begin
                t += 3;
            end
        end
        last = t;
        e_done[last] = 1;
        for (int c = 1; c <= last; c++) e_busy[c] = 1;
        if (mode == 1) begin
            tk[5] = 1;
            tk[last] = 1;
        end else if (mode == 2) begin
            for (int c = 1; c <= last; c++) tk[c] = ($urandom_range(0, 5) == 0);
        end
        stop = last;
        if (rst_at >= 0) begin
            stop = rst_at + 4;
            tk[rst_at] = 1;
            for (int c = rst_at + 1; c <= stop; c++) begin
                tk[c] = 0;
                rdy[c] = 0;
            end
        end
        for (int c = 0; c <= stop; c++) begin
            rst   = (c == rst_at);
            tick  = tk[c];
            ready = rdy[c];
            @(negedge clk);
            if (rst_at >= 0 && c > rst_at) begin
                chk_all_zero($sformatf("post_rst_c%0d", c));
            end else begin
                chk($sformatf("busy_c%0d", c),    32'(busy),    32'(e_busy[c]));
                chk($sformatf("rd_en_c%0d", c),   32'(rd_en),   32'(e_rd[c]));
                chk($sformatf("wr_en_c%0d", c),   32'(wr_en),   32'(e_wr[c]));
                chk($sformatf("valid_c%0d", c),   32'(valid),   32'(e_val[c]));
                chk($sformatf("done_c%0d", c),    32'(done),    32'(e_done[c]));
                chk($sformatf("overrun_c%0d", c), 32'(overrun), 32'(ovr_model));
                if (e_rd[c] || e_wr[c])
                    chk($sformatf("addr_c%0d", c), 32'(addr), 32'(e_addr[c]));
                if (e_wr[c])
                    chk($sformatf("wr_data_c%0d", c), 32'(wr_data), 32'(e_data[c]));
                if (e_val[c])
                    chk($sformatf("spike_id_c%0d", c), 32'(spike_id), 32'(e_id[c]));
                if (tk[c] && e_busy[c] && c != rst_at) ovr_model = 1'b1;
            end
            if (c == rst_at) ovr_model = 1'b0;
            @(posedge clk);
            #1;
        end
        rst  = 1'b0;
        tick = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < NN; k++) begin
            pot_tab[k] = '0;
            spk_tab[k] = 1'b0;
        end
        rst   = 1'b1;
        tick  = 1'b0;
        ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_sweep(1, -1);
        run_sweep(0, -1);
        run_sweep(0, -1);
        run_sweep(2, -1);
        run_sweep(0, 7);
        run_sweep(0, -1);
        run_sweep(2, -1);
        run_sweep(2, -1);
        run_sweep(0, 4);
        run_sweep(1, -1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
